vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Downstream stage of the pixel-processing core. Scans the 640x480 output frame buffer (4-bit grey pixels) in raster order using standard VGA timing.
- Issues read addresses to the buffer and absorbs its fixed read latency.
- Drives 4-bit R/G/B plus active-low hsync/vsync to the board DAC. Runs on the same 24 MHz pixel clock as the core, so no CDC is needed.

Parameters:
- width, 640, active pixels per line
- height, 480, active lines per frame
- hFront, 16, horizontal front porch (pixels)
- hSync, 96, hsync pulse width (pixels)
- hBack, 48, horizontal back porch (pixels)
- vFront, 10, vertical front porch (lines)
- vSync, 2, vsync pulse width (lines)
- vBack, 33, vertical back porch (lines)
- MEM_LAT, 1, frame-buffer read latency in cycles (range 1..4)
- Derived localparams: hMaxCount = width+hFront+hSync+hBack (800); vMaxCount = height+vFront+vSync+vBack (525)

Ports:
- clk24  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scan enable
- rd_addr  out  19  frame-buffer read address
- rd_data  in  4  frame-buffer read data, valid MEM_LAT cycles after rd_addr
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hsync  out  1  horizontal sync, active-low
- vga_vsync  out  1  vertical sync, active-low
- frame_end  out  1  one-cycle pulse on the last count of each frame

Behaviour:
- Reset is synchronous, active-high: hor=0, ver=0, rd_addr=0, vga_r/g/b=0, vga_hsync=1, vga_vsync=1, frame_end=0, all pipeline stages cleared (sync stages =1, active =0).
- Counters:
  - hor counts 0..hMaxCount-1.
  - At wrap, hor goes to 0 and ver increments.
  - ver wraps from vMaxCount-1 to 0 in the same cycle hor wraps.
  - Counters advance only while en=1.
  - en=0: counters cleared to 0 on the next edge; pipeline keeps shifting with active=0 and sync=1, so outputs blank within L cycles.
  - When en returns to 1, the scan restarts at hor=0, ver=0.
- Stage 0 (counters) computes:
  - active = hor<width && ver<height
  - hs_n = !(hor in [width+hFront, width+hFront+hSync))
  - vs_n = !(ver in [height+vFront, height+vFront+vSync))
- rd_addr is registered: hor + ver*width when active, else 0. Max value is 307199, so 19 bits are sufficient. Compute the multiply at 19 bits; no truncation is allowed.
- rd_data is sampled MEM_LAT cycles after the rd_addr edge.
- active, hs_n and vs_n are delayed by a shift register of depth MEM_LAT+1 so they align with rd_data.
- Output register:
  - vga_r = vga_g = vga_b = rd_data when the delayed active=1, else 0.
  - vga_hsync and vga_vsync are the delayed hs_n and vs_n.
- Total latency from counter state to pins is L = MEM_LAT+2 cycles. All outputs share the same latency, so the hsync-to-pixel phase is exact.
- frame_end:
  - Registered, asserted for exactly one cycle after the cycle with hor=hMaxCount-1, ver=vMaxCount-1, en=1.
  - Not pipeline-delayed.
  - Never asserted while en=0.
- Asserting rst mid-line takes effect on the next edge and overrides en. The partial frame is discarded and there is no frame_end pulse.
- There are no back-pressure or handshake signals; the frame buffer must always answer within MEM_LAT.

Optional Feature:
- Macro: VGA_SCANOUT_BORDER_EN.
- Defined:
  - Overlays a 1-pixel red frame (r=4'hF, g=0, b=0) on the rectangle rows 0 and height-1, columns 0 and width-1, at active pixels only.
  - Border detection is computed at stage 0 and delayed like active, so it is cycle-exact.
- Undefined: no overlay logic is synthesized; pixels pass through unchanged.

Decomposition:
- Shared package vga_pkg holds:
  - the timing defaults (640/480/16/96/48/10/2/33)
  - hMaxCount, vMaxCount
  - ADDR_W=19, PIX_W=4
  - a typedef struct {active, hs_n, vs_n, border} for the pipeline stage
- One sub-module is natural: vga_timing, which holds the hor/ver counters and decodes active/hs_n/vs_n/frame_end.
- vga_scanout instantiates vga_timing and adds address generation, the delay line and the output register.

Test Plan:
- Reset then en=1, MEM_LAT=1, rd_data=hor[3:0] model -> rd_addr sequence 0,1,2…639 then 0 during blanking. vga_r at cycle 3 after reset release = 4'h0, then 4'h1. Outputs are 0 in blanking.
- Sync timing -> vga_hsync low exactly 96 cycles starting at hor=656+L; period 800 cycles. vga_vsync low exactly 2 lines (1600 cycles) starting at ver=490.
- Frame length -> frame_end pulses once every 420000 cycles, width 1. First pulse 420000 cycles after en rises.
- Address math at line 479, hor 639 -> rd_addr=307199. Next active address is 0 at frame wrap.
- en dropped mid-line at hor=300, ver=100, then re-raised -> outputs blank within L cycles, no frame_end, rd_addr restarts at 0.
- MEM_LAT=3 with VGA_SCANOUT_BORDER_EN defined, rd_data constant 4'h8 -> row 0 outputs r=F, g=0, b=0. Interior pixels are 8/8/8 with latency 5.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan-out block: timing defaults, bus widths and the
// per-pixel pipeline stage record.
package vga_pkg;

   // 640x480 @ 60 Hz style timing, in pixels (horizontal) and lines (vertical)
   localparam int unsigned DefWidth  = 640;
   localparam int unsigned DefHeight = 480;
   localparam int unsigned DefHFront = 16;
   localparam int unsigned DefHSync  = 96;
   localparam int unsigned DefHBack  = 48;
   localparam int unsigned DefVFront = 10;
   localparam int unsigned DefVSync  = 2;
   localparam int unsigned DefVBack  = 33;

   localparam int unsigned HMaxCount = DefWidth + DefHFront + DefHSync + DefHBack;
   localparam int unsigned VMaxCount = DefHeight + DefVFront + DefVSync + DefVBack;

   localparam int unsigned ADDR_W = 19;
   localparam int unsigned PIX_W  = 4;
   // Counter width; covers totals up to 1023 pixels per line and lines per frame
   localparam int unsigned CntW   = 10;

   // One pixel's worth of control travelling alongside the frame-buffer read
   typedef struct packed {
      logic active;
      logic hs_n;
      logic vs_n;
      logic border;
   } pipe_t;

   // Blanked stage: no pixel, both syncs inactive
   localparam pipe_t PipeIdle = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, border: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the VGA scan-out plus stage-0 decode of active video, syncs,
// border (only when VGA_SCANOUT_BORDER_EN is defined) and the end-of-frame pulse.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned Width  = DefWidth,
   parameter int unsigned Height = DefHeight,
   parameter int unsigned HFront = DefHFront,
   parameter int unsigned HSync  = DefHSync,
   parameter int unsigned HBack  = DefHBack,
   parameter int unsigned VFront = DefVFront,
   parameter int unsigned VSync  = DefVSync,
   parameter int unsigned VBack  = DefVBack
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            en_i,
   output logic [CntW-1:0] hor_o,
   output logic [CntW-1:0] ver_o,
   output pipe_t           stage_o,
   output logic            frame_end_o
);

   localparam int unsigned HMax = Width + HFront + HSync + HBack;
   localparam int unsigned VMax = Height + VFront + VSync + VBack;

   localparam logic [CntW-1:0] HLast     = CntW'(HMax - 1);
   localparam logic [CntW-1:0] VLast     = CntW'(VMax - 1);
   localparam logic [CntW-1:0] HActEnd   = CntW'(Width);
   localparam logic [CntW-1:0] VActEnd   = CntW'(Height);
   localparam logic [CntW-1:0] HSyncBeg  = CntW'(Width + HFront);
   localparam logic [CntW-1:0] HSyncEnd  = CntW'(Width + HFront + HSync);
   localparam logic [CntW-1:0] VSyncBeg  = CntW'(Height + VFront);
   localparam logic [CntW-1:0] VSyncEnd  = CntW'(Height + VFront + VSync);

   logic [CntW-1:0] hor_d, hor_q;
   logic [CntW-1:0] ver_d, ver_q;
   logic            frame_end_d, frame_end_q;

   // Next counter state; dropping en parks the scan at the top-left corner
   always_comb begin
      hor_d       = hor_q;
      ver_d       = ver_q;
      frame_end_d = 1'b0;
      if (!en_i) begin
         hor_d = '0;
         ver_d = '0;
      end else if (hor_q == HLast) begin
         hor_d = '0;
         if (ver_q == VLast) begin
            ver_d       = '0;
            frame_end_d = 1'b1;
         end else begin
            ver_d = ver_q + 1'b1;
         end
      end else begin
         hor_d = hor_q + 1'b1;
      end
   end

   // Counter and frame-end registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hor_q       <= '0;
         ver_q       <= '0;
         frame_end_q <= 1'b0;
      end else begin
         hor_q       <= hor_d;
         ver_q       <= ver_d;
         frame_end_q <= frame_end_d;
      end
   end

   // Stage-0 decode; while disabled the stage is forced blank so the pipe drains
   always_comb begin
      stage_o = PipeIdle;
      if (en_i) begin
         stage_o.active = (hor_q < HActEnd) && (ver_q < VActEnd);
         stage_o.hs_n   = !((hor_q >= HSyncBeg) && (hor_q < HSyncEnd));
         stage_o.vs_n   = !((ver_q >= VSyncBeg) && (ver_q < VSyncEnd));
`ifdef VGA_SCANOUT_BORDER_EN
         stage_o.border = stage_o.active &&
                          ((hor_q == '0) || (hor_q == HActEnd - 1'b1) ||
                           (ver_q == '0) || (ver_q == VActEnd - 1'b1));
`endif
      end
   end

   assign hor_o       = hor_q;
   assign ver_o       = ver_q;
   assign frame_end_o = frame_end_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: raster-order frame-buffer reads, latency-matched control delay line and
// registered DAC outputs. Optional red border overlay under VGA_SCANOUT_BORDER_EN.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int unsigned Width   = DefWidth,
   parameter int unsigned Height  = DefHeight,
   parameter int unsigned HFront  = DefHFront,
   parameter int unsigned HSync   = DefHSync,
   parameter int unsigned HBack   = DefHBack,
   parameter int unsigned VFront  = DefVFront,
   parameter int unsigned VSync   = DefVSync,
   parameter int unsigned VBack   = DefVBack,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk24_i,
   input  logic              rst_i,
   input  logic              en_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [PIX_W-1:0]  rd_data_i,
   output logic [PIX_W-1:0]  vga_r_o,
   output logic [PIX_W-1:0]  vga_g_o,
   output logic [PIX_W-1:0]  vga_b_o,
   output logic              vga_hsync_o,
   output logic              vga_vsync_o,
   output logic              frame_end_o
);

   // One stage for the address register plus MEM_LAT for the buffer
   localparam int Depth = int'(MEM_LAT) + 1;

   logic [CntW-1:0] hor, ver;
   pipe_t           stage0;

   vga_timing #(
      .Width  (Width),
      .Height (Height),
      .HFront (HFront),
      .HSync  (HSync),
      .HBack  (HBack),
      .VFront (VFront),
      .VSync  (VSync),
      .VBack  (VBack)
   ) u_timing (
      .clk_i       (clk24_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .hor_o       (hor),
      .ver_o       (ver),
      .stage_o     (stage0),
      .frame_end_o (frame_end_o)
   );

   logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
   pipe_t             dly_d [Depth];
   pipe_t             dly_q [Depth];
   pipe_t             tail;
   logic [PIX_W-1:0]  r_d, r_q, g_d, g_q, b_d, b_q;
   logic              hsync_d, hsync_q, vsync_d, vsync_q;

   // Linear address of the current pixel, full 19-bit product; 0 during blanking
   always_comb begin
      rd_addr_d = '0;
      if (stage0.active) begin
         rd_addr_d = ADDR_W'(hor) + ADDR_W'(ver) * ADDR_W'(Width);
      end
   end

   // Control delay line shifts stage-0 decode so it lines up with rd_data
   always_comb begin
      dly_d[0] = stage0;
      for (int i = 1; i < Depth; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   assign tail = dly_q[Depth-1];

   // Output pixel select: blank, buffer data, or border colour
   always_comb begin
      r_d     = '0;
      g_d     = '0;
      b_d     = '0;
      hsync_d = tail.hs_n;
      vsync_d = tail.vs_n;
      if (tail.active) begin
         r_d = rd_data_i;
         g_d = rd_data_i;
         b_d = rd_data_i;
      end
`ifdef VGA_SCANOUT_BORDER_EN
      if (tail.border) begin
         r_d = '1;
         g_d = '0;
         b_d = '0;
      end
`endif
   end

`ifndef VGA_SCANOUT_BORDER_EN
   // Border bit is always clear in this build
   logic unused_border;
   assign unused_border = tail.border;
`endif

   // Address, delay-line and DAC output registers
   always_ff @(posedge clk24_i) begin
      if (rst_i) begin
         rd_addr_q <= '0;
         for (int i = 0; i < Depth; i++) begin
            dly_q[i] <= PipeIdle;
         end
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         rd_addr_q <= rd_addr_d;
         dly_q     <= dly_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
      end
   end

   assign rd_addr_o   = rd_addr_q;
   assign vga_r_o     = r_q;
   assign vga_g_o     = g_q;
   assign vga_b_o     = b_q;
   assign vga_hsync_o = hsync_q;
   assign vga_vsync_o = vsync_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: one full-size instance (line timing, addresses, en drop) and one
// small-geometry instance (whole frames, vsync, frame_end, mid-line reset).
// With VGA_SCANOUT_BORDER_EN defined the buffer returns a constant 4'h8 and MEM_LAT=3.
module tb_vga_scanout;

`ifdef VGA_SCANOUT_BORDER_EN
   localparam int Lat = 3;
`else
   localparam int Lat = 1;
`endif

   // Small geometry: 8x4 active, 14 pixels per line, 8 lines per frame
   localparam int SW = 8;
   localparam int SH = 4;
   localparam int SHM = 14;
   localparam int SVM = 8;
   localparam int SFrame = SHM * SVM;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        d_rst, d_en, d_hs, d_vs, d_fe;
   logic [18:0] d_rd_addr;
   logic [3:0]  d_rd_data, d_r, d_g, d_b;
   logic        s_rst, s_en, s_hs, s_vs, s_fe;
   logic [18:0] s_rd_addr;
   logic [3:0]  s_rd_data, s_r, s_g, s_b;

   vga_scanout #(
      .MEM_LAT (Lat)
   ) u_dut_full (
      .clk24_i     (clk),
      .rst_i       (d_rst),
      .en_i        (d_en),
      .rd_addr_o   (d_rd_addr),
      .rd_data_i   (d_rd_data),
      .vga_r_o     (d_r),
      .vga_g_o     (d_g),
      .vga_b_o     (d_b),
      .vga_hsync_o (d_hs),
      .vga_vsync_o (d_vs),
      .frame_end_o (d_fe)
   );

   vga_scanout #(
      .Width   (SW),
      .Height  (SH),
      .HFront  (2),
      .HSync   (3),
      .HBack   (1),
      .VFront  (1),
      .VSync   (2),
      .VBack   (1),
      .MEM_LAT (Lat)
   ) u_dut_small (
      .clk24_i     (clk),
      .rst_i       (s_rst),
      .en_i        (s_en),
      .rd_addr_o   (s_rd_addr),
      .rd_data_i   (s_rd_data),
      .vga_r_o     (s_r),
      .vga_g_o     (s_g),
      .vga_b_o     (s_b),
      .vga_hsync_o (s_hs),
      .vga_vsync_o (s_vs),
      .frame_end_o (s_fe)
   );

   // Frame-buffer models: data appears Lat cycles after the address edge
   logic [18:0] d_pipe [Lat];
   logic [18:0] s_pipe [Lat];
   always @(posedge clk) begin
      d_pipe[0] <= d_rd_addr;
      s_pipe[0] <= s_rd_addr;
      for (int i = 1; i < Lat; i++) begin
         d_pipe[i] <= d_pipe[i-1];
         s_pipe[i] <= s_pipe[i-1];
      end
   end
`ifdef VGA_SCANOUT_BORDER_EN
   assign d_rd_data = 4'h8;
   assign s_rd_data = 4'h8;
`else
   assign d_rd_data = d_pipe[Lat-1][3:0];
   assign s_rd_data = s_pipe[Lat-1][3:0];
`endif

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {r,g,b} for raster position (hor, ver) of a w x h frame
`ifdef VGA_SCANOUT_BORDER_EN
   function automatic logic [11:0] exp_pix(input int hor, input int ver, input int w,
                                           input int h);
      if (hor >= w || ver >= h) return 12'h000;
      if (hor == 0 || ver == 0 || hor == w - 1 || ver == h - 1) return 12'hF00;
      return 12'h888;
   endfunction
`else
   function automatic logic [11:0] exp_pix(input int hor, input int ver, input int w,
                                           input int h);
      logic [3:0] a;
      if (hor >= w || ver >= h) return 12'h000;
      a = 4'((hor + ver * w) % 16);
      return {a, a, a};
   endfunction
`endif

   int fall1 = -1, rise1 = -1, fall2 = -1;
   int bad_vs = 0, bad_fe = 0;
   logic prev_hs = 1'b1;
   int fe_cnt = 0, vs_low = 0, vs_fall = -1;
   int fe_pos [3];
   logic prev_vs = 1'b1;

   initial begin
      d_rst = 1'b1; d_en = 1'b0;
      s_rst = 1'b1; s_en = 1'b0;
      for (int i = 0; i < 3; i++) fe_pos[i] = -1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_addr", d_rd_addr, 0);
      check("rst_rgb", {d_r, d_g, d_b}, 0);
      check("rst_hsync", d_hs, 1);
      check("rst_vsync", d_vs, 1);
      check("rst_fe", d_fe, 0);

      // Full-size scan: two lines plus part of a third
      d_rst = 1'b0; d_en = 1'b1;
      for (int j = 0; j < 1900; j++) begin
         int k;
         @(negedge clk);
         k = j - Lat - 1;
         case (j)
            0:    check("addr_0", d_rd_addr, 0);
            1:    check("addr_1", d_rd_addr, 1);
            639:  check("addr_639", d_rd_addr, 639);
            640:  check("addr_blank", d_rd_addr, 0);
            800:  check("addr_line1", d_rd_addr, 640);
            801:  check("addr_line1_1", d_rd_addr, 641);
            1439: check("addr_line1_end", d_rd_addr, 1279);
            default: ;
         endcase
         if (k == 0 || k == 1 || k == 639 || k == 640 || k == 800 || k == 801 || k == 900)
            check($sformatf("pix_k%0d", k), {d_r, d_g, d_b}, exp_pix(k % 800, k / 800, 640, 480));
         if (prev_hs && !d_hs) begin
            if (fall1 < 0) fall1 = j;
            else if (fall2 < 0) fall2 = j;
         end
         if (!prev_hs && d_hs && rise1 < 0) rise1 = j;
         prev_hs = d_hs;
         if (!d_vs) bad_vs++;
         if (d_fe) bad_fe++;
      end
      check("hsync_fall", fall1, 656 + Lat + 1);
      check("hsync_width", rise1 - fall1, 96);
      check("hsync_period", fall2 - fall1, 800);
      check("vsync_idle", bad_vs, 0);

      // Drop en mid-line (line 2, hor 300), then re-raise
      d_en = 1'b0;
      for (int m = 0; m < 12; m++) begin
         @(negedge clk);
         if (d_fe) bad_fe++;
         if (m == 0) check("en_off_addr", d_rd_addr, 0);
         if (m == Lat + 1) begin
            check("en_off_blank", {d_r, d_g, d_b}, 0);
            check("en_off_hsync", d_hs, 1);
         end
         if (m == 11) check("en_off_still", {d_r, d_g, d_b}, 0);
      end
      check("en_off_fe", bad_fe, 0);
      d_en = 1'b1;
      for (int j = 0; j < Lat + 3; j++) begin
         @(negedge clk);
         if (j == 0) check("restart_addr0", d_rd_addr, 0);
         if (j == 1) check("restart_addr1", d_rd_addr, 1);
         if (j == Lat + 1) check("restart_pix0", {d_r, d_g, d_b}, exp_pix(0, 0, 640, 480));
         if (j == Lat + 2) check("restart_pix1", {d_r, d_g, d_b}, exp_pix(1, 0, 640, 480));
      end
      d_rst = 1'b1;

      // Small geometry: three whole frames
      s_rst = 1'b0; s_en = 1'b1;
      for (int j = 0; j < 3 * SFrame; j++) begin
         int k;
         @(negedge clk);
         k = j - Lat - 1;
         case (j)
            31:  check("s_addr_19", s_rd_addr, 19);
            49:  check("s_addr_last", s_rd_addr, SW * SH - 1);
            50:  check("s_addr_blank", s_rd_addr, 0);
            112: check("s_addr_wrap", s_rd_addr, 0);
            113: check("s_addr_wrap1", s_rd_addr, 1);
            126: check("s_addr_line1", s_rd_addr, 8);
            default: ;
         endcase
         if (k >= 0)
            check("s_pix", {s_r, s_g, s_b},
                  exp_pix((k % SFrame) % SHM, (k % SFrame) / SHM, SW, SH));
         if (s_fe) begin
            if (fe_cnt < 3) fe_pos[fe_cnt] = j;
            fe_cnt++;
         end
         if (j < SFrame) begin
            if (!s_vs) vs_low++;
            if (prev_vs && !s_vs && vs_fall < 0) vs_fall = j;
            prev_vs = s_vs;
         end
      end
      check("s_fe_count", fe_cnt, 3);
      check("s_fe_pos0", fe_pos[0], SFrame - 1);
      check("s_fe_pos1", fe_pos[1], 2 * SFrame - 1);
      check("s_fe_pos2", fe_pos[2], 3 * SFrame - 1);
      check("s_vsync_fall", vs_fall, 70 + Lat + 1);
      check("s_vsync_width", vs_low, 2 * SHM);

      // Reset mid-line with en still high: partial frame discarded
      repeat (38) @(negedge clk);
      s_rst = 1'b1;
      @(negedge clk);
      check("s_rst_addr", s_rd_addr, 0);
      check("s_rst_rgb", {s_r, s_g, s_b}, 0);
      check("s_rst_hsync", s_hs, 1);
      check("s_rst_fe", s_fe, 0);
      @(negedge clk);
      s_rst = 1'b0;
      fe_cnt = 0;
      fe_pos[0] = -1;
      for (int j = 0; j < 120; j++) begin
         @(negedge clk);
         if (s_fe) begin
            if (fe_cnt == 0) fe_pos[0] = j;
            fe_cnt++;
         end
         if (j == Lat + 1) check("s_rst_pix0", {s_r, s_g, s_b}, exp_pix(0, 0, SW, SH));
         if (j == Lat + 2) check("s_rst_pix1", {s_r, s_g, s_b}, exp_pix(1, 0, SW, SH));
      end
      check("s_rst_fe_count", fe_cnt, 1);
      check("s_rst_fe_pos", fe_pos[0], SFrame - 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
